// File: rtl/launch_pkg.sv
// launch_pkg: shared state/request enums and default constants for the launch parameter controller.
package launch_pkg;
    typedef enum logic {IDLE, HOLD} state_t;
    typedef enum logic [2:0] {NONE, AUP, ADN, PUP, PDN} req_t;
    localparam int ANG_W_D    = 5;
    localparam int ANG_MAX_D  = 16;
    localparam int VEL_W_D    = 3;
    localparam int VEL_MAX_D  = 5;
    localparam int ANG_HOLD_D = 3;
    localparam int VEL_HOLD_D = 6;
    localparam int X0_D       = 42;
    localparam int Y0_D       = 425;
    localparam int ANG_DX_D   = 1;
    localparam int ANG_DY_D   = 4;
    localparam int VEL_DX_D   = 4;
    localparam int VEL_DY_D   = 10;
    localparam int MARK_SZ_D  = 5;
    localparam int HOLD_W     = 8;
endpackage

// File: rtl/holdoff_timer.sv
// holdoff_timer: tick-driven countdown; done pulses on the tick where the count reads 1.
module holdoff_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         tick,
    output logic         done
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (load)
            r_cnt <= (value == '0) ? W'(1) : value;
        else if (tick && r_cnt != '0)
            r_cnt <= r_cnt - W'(1);
    end
    assign done = tick && r_cnt == W'(1);
endmodule

// File: rtl/launch_param_ctrl.sv
// launch_param_ctrl: button-driven angle/velocity stepping with hold-off and an aiming marker.
module launch_param_ctrl
    import launch_pkg::*;
#(
    parameter int ANG_W    = ANG_W_D,
    parameter int ANG_MAX  = ANG_MAX_D,
    parameter int VEL_W    = VEL_W_D,
    parameter int VEL_MAX  = VEL_MAX_D,
    parameter int ANG_HOLD = ANG_HOLD_D,
    parameter int VEL_HOLD = VEL_HOLD_D,
    parameter int X0       = X0_D,
    parameter int Y0       = Y0_D,
    parameter int ANG_DX   = ANG_DX_D,
    parameter int ANG_DY   = ANG_DY_D,
    parameter int VEL_DX   = VEL_DX_D,
    parameter int VEL_DY   = VEL_DY_D,
    parameter int MARK_SZ  = MARK_SZ_D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             angleup,
    input  logic             angledown,
    input  logic             powerup,
    input  logic             powerdown,
    input  logic             lock,
    input  logic [9:0]       xCount,
    input  logic [9:0]       yCount,
    output logic             arrow,
    output logic [ANG_W-1:0] Ang,
    output logic [VEL_W-1:0] Vel,
    output logic [9:0]       markX,
    output logic [9:0]       markY,
    output logic             busy
);
    localparam logic [ANG_W-1:0]  AMAX = ANG_W'(ANG_MAX);
    localparam logic [VEL_W-1:0]  VMAX = VEL_W'(VEL_MAX);
    localparam logic [HOLD_W-1:0] AH   = HOLD_W'(ANG_HOLD);
    localparam logic [HOLD_W-1:0] VH   = HOLD_W'(VEL_HOLD);
    localparam logic [9:0]        ADX  = 10'(ANG_DX);
    localparam logic [9:0]        ADY  = 10'(ANG_DY);
    localparam logic [9:0]        VDX  = 10'(VEL_DX);
    localparam logic [9:0]        VDY  = 10'(VEL_DY);
    localparam logic [10:0]       MSZ  = 11'(MARK_SZ);

    state_t            r_state, w_state_nx;
    req_t              w_req;
    logic              w_load, w_done, w_hit;
    logic [HOLD_W-1:0] w_hold_val;
    logic [ANG_W-1:0]  r_ang;
    logic [VEL_W-1:0]  r_vel;
    logic [9:0]        r_mx, r_my;
    logic              r_arrow;

    // Saturated requests fall through to the next lower priority.
    assign w_req = (!angleup   && r_ang < AMAX)  ? AUP :
                   (!angledown && r_ang != '0)   ? ADN :
                   (!powerup   && r_vel < VMAX)  ? PUP :
                   (!powerdown && r_vel != '0)   ? PDN : NONE;
    assign w_hold_val = (w_req == AUP || w_req == ADN) ? AH : VH;

    always_comb begin
        w_load     = r_state == IDLE && tick && !lock && w_req != NONE;
        w_state_nx = w_load ? HOLD : (r_state == HOLD && w_done) ? IDLE : r_state;
    end

    holdoff_timer #(.W(HOLD_W)) u_hold (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .value (w_hold_val),
        .tick  (tick),
        .done  (w_done)
    );

    // Marker box bounds are compared in 11 bits so markX+MARK_SZ never wraps.
    assign w_hit = xCount > r_mx && {1'b0, xCount} < {1'b0, r_mx} + MSZ &&
                   yCount > r_my && {1'b0, yCount} < {1'b0, r_my} + MSZ;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_ang   <= '0;
            r_vel   <= '0;
            r_mx    <= 10'(X0);
            r_my    <= 10'(Y0);
            r_arrow <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_arrow <= w_hit;
            if (w_load) begin
                case (w_req)
                    AUP: begin r_ang <= r_ang + ANG_W'(1); r_mx <= r_mx - ADX; r_my <= r_my - ADY; end
                    ADN: begin r_ang <= r_ang - ANG_W'(1); r_mx <= r_mx + ADX; r_my <= r_my + ADY; end
                    PUP: begin r_vel <= r_vel + VEL_W'(1); r_mx <= r_mx + VDX; r_my <= r_my - VDY; end
                    PDN: begin r_vel <= r_vel - VEL_W'(1); r_mx <= r_mx - VDX; r_my <= r_my + VDY; end
                    default: ;
                endcase
            end
        end
    end

    assign arrow = r_arrow;
    assign Ang   = r_ang;
    assign Vel   = r_vel;
    assign markX = r_mx;
    assign markY = r_my;
    assign busy  = r_state == HOLD;
endmodule

// File: tb/tb_launch_param_ctrl.sv
// tb_launch_param_ctrl: directed and random steps checked against a tick-level behavioural model.
module tb_launch_param_ctrl;
    logic       clk = 0, rst = 1, tick = 0, lock = 0;
    logic       angleup = 1, angledown = 1, powerup = 1, powerdown = 1;
    logic [9:0] xCount = 0, yCount = 0;
    logic       arrow, busy;
    logic [4:0] Ang;
    logic [2:0] Vel;
    logic [9:0] markX, markY;
    int checks = 0, errors = 0;
    int m_ang, m_vel, m_mx, m_my, m_hold, prev;
    bit m_arrow;

    always #5 clk = ~clk;

    launch_param_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .angleup(angleup), .angledown(angledown),
        .powerup(powerup), .powerdown(powerdown), .lock(lock), .xCount(xCount),
        .yCount(yCount), .arrow(arrow), .Ang(Ang), .Vel(Vel), .markX(markX),
        .markY(markY), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("ang", Ang, m_ang);
        check("vel", Vel, m_vel);
        check("markX", markX, m_mx);
        check("markY", markY, m_my);
        check("busy", busy, m_hold > 0);
        check("arrow", arrow, m_arrow);
    endtask

    // b = {angleup, angledown, powerup, powerdown}, active low
    task automatic step(input bit t, input bit [3:0] b, input bit lk, input int x, input int y);
        tick = t;
        {angleup, angledown, powerup, powerdown} = b;
        lock = lk;
        xCount = 10'(x);
        yCount = 10'(y);
        m_arrow = (m_mx < x) && (x < m_mx + 5) && (m_my < y) && (y < m_my + 5);
        if (t) begin
            if (m_hold > 0) m_hold--;
            else if (!lk) begin
                if (!b[3] && m_ang < 16) begin
                    m_ang++; m_mx = (m_mx - 1) & 1023; m_my = (m_my - 4) & 1023; m_hold = 3;
                end else if (!b[2] && m_ang > 0) begin
                    m_ang--; m_mx = (m_mx + 1) & 1023; m_my = (m_my + 4) & 1023; m_hold = 3;
                end else if (!b[1] && m_vel < 5) begin
                    m_vel++; m_mx = (m_mx + 4) & 1023; m_my = (m_my - 10) & 1023; m_hold = 6;
                end else if (!b[0] && m_vel > 0) begin
                    m_vel--; m_mx = (m_mx - 4) & 1023; m_my = (m_my + 10) & 1023; m_hold = 6;
                end
            end
        end
        @(posedge clk);
        #1;
        tick = 0;
        check_all();
    endtask

    task automatic do_reset(input bit t);
        rst = 1;
        tick = t;
        {angleup, angledown, powerup, powerdown} = 4'b0000;
        lock = 1'($urandom);
        @(posedge clk);
        #1;
        rst = 0;
        tick = 0;
        {angleup, angledown, powerup, powerdown} = 4'b1111;
        lock = 0;
        m_ang = 0; m_vel = 0; m_mx = 42; m_my = 425; m_hold = 0; m_arrow = 0;
        check_all();
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset(1);
        check("reset_markX", markX, 42);
        check("reset_markY", markY, 425);

        step(1, 4'b0111, 0, 0, 0);
        check("aup_t1", Ang, 1);
        repeat (4) step(1, 4'b0111, 0, 0, 0);
        check("aup_t5", Ang, 2);
        check("aup_t5_mx", markX, 40);
        check("aup_t5_my", markY, 417);
        repeat (7) step(1, 4'b0111, 0, 0, 0);
        repeat (60) step(1, 4'b0111, 0, 0, 0);
        check("ang_sat", Ang, 16);
        check("ang_sat_mx", markX, 26);
        check("ang_sat_my", markY, 361);

        do_reset(0);
        repeat (42) step(1, 4'b1101, 0, 0, 0);
        check("vel_sat", Vel, 5);
        check("vel_sat_mx", markX, 62);
        check("vel_sat_my", markY, 375);
        check("vel_sat_idle", busy, 0);

        do_reset(1);
        repeat (3) begin
            step(1, 4'b0101, 0, 0, 0);
            check("both_busy", busy, 1);
        end
        step(1, 4'b1111, 0, 0, 0);
        check("both_ang", Ang, 1);
        check("both_vel", Vel, 0);
        check("both_done", busy, 0);

        do_reset(0);
        repeat (2) begin
            step(1, 4'b1101, 0, 0, 0);
            while (m_hold > 0) step(1, 4'b1111, 0, 0, 0);
        end
        prev = int'(markX);
        step(1, 4'b1010, 0, 0, 0);
        check("fall_vel", Vel, 1);
        check("fall_ang", Ang, 0);
        check("fall_mx", markX, (prev - 4) & 1023);

        do_reset(0);
        repeat (20) step(1, 4'b0000, 1, 0, 0);
        check("lock_ang", Ang, 0);
        check("lock_busy", busy, 0);
        step(1, 4'b0111, 0, 0, 0);
        repeat (3) step(1, 4'b0000, 1, 0, 0);
        check("lock_hold_done", busy, 0);
        check("lock_hold_ang", Ang, 1);
        step(1, 4'b0111, 0, 0, 0);
        step(1, 4'b1111, 0, 0, 0);
        do_reset(1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ang", Ang, 0);

        for (int x = 41; x <= 48; x++)
            for (int y = 424; y <= 431; y++)
                step(0, 4'b1111, 0, x, y);
        step(0, 4'b1111, 0, 44, 427);
        check("scan_in", arrow, 1);
        step(0, 4'b1111, 0, 47, 427);
        check("scan_x47", arrow, 0);
        step(0, 4'b1111, 0, 42, 427);
        check("scan_x42", arrow, 0);

        repeat (600) begin
            if ($urandom_range(0, 99) < 2) do_reset(1'($urandom));
            else step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 7) == 0,
                      (m_mx + $urandom_range(0, 6) - 1) & 1023,
                      (m_my + $urandom_range(0, 6) - 1) & 1023);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
